// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU with a one-deep registered result slot
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [2:0]        alu_op,
  input  logic [W-1:0]      alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, rsp_id_q, rsp_id_d, gnt, cand;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           found, can_accept, xfer;
  // first valid requester at or after ptr, wrapping; idle cycles park the ALU on ptr
  always_comb begin
    found = 1'b0;
    gnt   = ptr_q;
    cand  = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end
  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign xfer       = found && can_accept && !rst;
  assign req_ready  = xfer ? NREQ'(1) << gnt : '0;
  assign alu_a      = req_a[int'(gnt)*W +: W];
  assign alu_b      = req_b[int'(gnt)*W +: W];
  assign alu_op     = req_op[int'(gnt)*3 +: 3];
  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  // a transfer refills the slot (even while draining); a drain alone empties it
  always_comb begin
    state_d    = xfer ? FULL : (rsp_ready ? EMPTY : state_q);
    rsp_data_d = xfer ? alu_out : rsp_data_q;
    rsp_id_d   = xfer ? gnt : rsp_id_q;
    ptr_d      = xfer ? IDW'((int'(gnt) + 1) % NREQ) : ptr_q;
  end
  // result slot and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      ptr_q      <= ptr_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;
  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*3-1:0] req_op;
  logic [W-1:0]      alu_a, alu_b, alu_out, rsp_data;
  logic [2:0]        alu_op;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      ta [NREQ];
  logic [W-1:0]      tb [NREQ];
  logic [2:0]        top [NREQ];
  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr, m_id, e_g;
  bit m_full, e_found, e_xfer;
  logic [W-1:0] m_data;
  int wait_x [NREQ];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      3'd0: alu_fn = a + b;
      3'd1: alu_fn = a - b;
      3'd2: alu_fn = a << b[4:0];
      3'd3: alu_fn = a >> b[4:0];
      3'd4: alu_fn = a & b;
      3'd5: alu_fn = $signed(a) >>> b[4:0];
      3'd6: alu_fn = a | b;
      default: alu_fn = a ^ b;
    endcase
  endfunction

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tb[i];
      req_op[i*3 +: 3] = top[i];
    end
  end

  assign alu_out = alu_fn(alu_a, alu_b, alu_op);

  alu_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // the model's view of this cycle: who should win and whether a transfer happens
  task automatic model_eval();
    bit can;
    can = !m_full || rsp_ready;
    e_found = 1'b0;
    e_g = m_ptr;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (!e_found && req_valid[c]) begin
        e_found = 1'b1;
        e_g = c;
      end
    end
    e_xfer = e_found && can && !rst;
  endtask

  task automatic check_cycle();
    int s;
    logic [NREQ-1:0] er;
    model_eval();
    s = e_found ? e_g : m_ptr;
    er = '0;
    if (e_xfer) er[e_g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("alu_a", 64'(alu_a), 64'(ta[s]));
    chk("alu_b", 64'(alu_b), 64'(tb[s]));
    chk("alu_op", 64'(alu_op), 64'(top[s]));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
    if (m_full) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_data", 64'(rsp_data), 64'(m_data));
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_ptr = 0;
      m_full = 1'b0;
      m_id = 0;
      m_data = '0;
      for (int i = 0; i < NREQ; i++) wait_x[i] = 0;
    end else if (e_xfer) begin
      m_data = alu_fn(ta[e_g], tb[e_g], top[e_g]);
      m_id = e_g;
      m_full = 1'b1;
      m_ptr = (e_g + 1) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (i == e_g || !req_valid[i]) wait_x[i] = 0;
        else begin
          wait_x[i]++;
          chk("fairness", 64'(wait_x[i] < NREQ), 64'd1);
        end
      end
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      ta[i] = '0;
      tb[i] = '0;
      top[i] = '0;
      wait_x[i] = 0;
    end
    m_ptr = 0; m_full = 1'b0; m_id = 0; m_data = '0;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_id", 64'(rsp_id), 64'd0);
    chk("reset rsp_data", 64'(rsp_data), 64'd0);
    // single request
    ta[0] = 32'd7; tb[0] = 32'd5; top[0] = 3'd0; req_valid = 4'b0001;
    #1 chk("t1 ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    chk("t1 valid", 64'(rsp_valid), 64'd1);
    chk("t1 id", 64'(rsp_id), 64'd0);
    chk("t1 data", 64'(rsp_data), 64'd12);
    chk("t1 model", 64'(m_data), 64'd12);
    // all requesters valid, back-to-back
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ta[i] = 32'(100 * (i + 1)); tb[i] = 32'(i); top[i] = 3'd0;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t2 ready", 64'(req_ready), 64'(1 << (k % 4)));
      step();
      chk("t2 id", 64'(rsp_id), 64'(k % 4));
      chk("t2 data", 64'(rsp_data), 64'(100 * (k % 4 + 1) + k % 4));
    end
    // backpressure
    rsp_ready = 1'b0; req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t3 ready held", 64'(req_ready), 64'd0);
      step();
      chk("t3 id stable", 64'(rsp_id), 64'd0);
      chk("t3 data stable", 64'(rsp_data), 64'd100);
    end
    rsp_ready = 1'b1;
    #1 chk("t3 release ready", 64'(req_ready), 64'b0010);
    step();
    chk("t3 id", 64'(rsp_id), 64'd1);
    chk("t3 data", 64'(rsp_data), 64'd201);
    // signed / logical right shifts
    req_valid = 4'b0100; ta[2] = 32'hFFFF_FFF8; tb[2] = 32'd2; top[2] = 3'd5;
    step();
    chk("t4 sra", 64'(rsp_data), 64'hFFFF_FFFE);
    top[2] = 3'd3;
    step();
    chk("t4 shr", 64'(rsp_data), 64'h3FFF_FFFE);
    // pointer wrap
    req_valid = 4'b1000;
    step();
    chk("t5 id3", 64'(rsp_id), 64'd3);
    req_valid = 4'b1001;
    #1 chk("t5 ready0", 64'(req_ready), 64'b0001);
    step();
    chk("t5 id0", 64'(rsp_id), 64'd0);
    #1 chk("t5 ready3", 64'(req_ready), 64'b1000);
    step();
    chk("t5 id3b", 64'(rsp_id), 64'd3);
    // reset while full with a valid request
    req_valid = 4'b0010; rst = 1'b1;
    #1 chk("t6 ready in reset", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0; req_valid = '0;
    #1 chk("t6 rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6 model ptr", 64'(m_ptr), 64'd0);
    req_valid = 4'b1111;
    #1 chk("t6 ptr restart", 64'(req_ready), 64'b0001);
    step();
    // randomized traffic; requesters hold a pending request stable
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !(e_xfer && e_g == i))) begin
          req_valid[i] = $urandom_range(0, 2) != 0;
          ta[i] = $urandom;
          tb[i] = $urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(0, 40));
          top[i] = 3'($urandom_range(0, 7));
        end
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
